// File: rtl/simple_and.sv
// Registered, enable-gated bitwise AND of two operand vectors.
// One-cycle latency, async active-low clear, hold when not enabled.
module simple_and #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             inclk,
  input  logic             inrst_n,
  input  logic             inen,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic [WIDTH-1:0] outy
);

  localparam int unsigned W_MIN = 1;
  localparam int unsigned W_MAX = 64;

  generate
    if (WIDTH < W_MIN || WIDTH > W_MAX) begin : g_bad_width
      $error("simple_and: WIDTH=%0d outside legal range 1..64", WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_and;

  assign w_and = ina & inb;

  // Only a definite 1 on inen loads; X/Z on enable leaves the result untouched.
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      r_y <= '0;
    end else if (inen === 1'b1) begin
      r_y <= w_and;
    end
  end

  assign outy = r_y;

`ifndef SYNTHESIS
  logic             r_chk_en;
  logic             r_chk_ok;
  logic [WIDTH-1:0] r_chk_y;

  always @(posedge inclk) begin
    if (inrst_n === 1'b1 && inen !== 1'b1 && inen !== 1'b0) begin
      $warning("simple_and: inen unknown at capture edge, result held");
    end
  end

  always @(posedge inclk) begin
    r_chk_en <= (inen === 1'b1);
  end

  // Between two falling edges with no enabled capture and no reset, outy must not move.
  always @(negedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      r_chk_ok <= 1'b0;
      r_chk_y  <= '0;
    end else begin
      if (r_chk_ok && !r_chk_en) begin
        a_hold : assert (outy == r_chk_y)
          else $error("simple_and: outy changed while disabled");
      end
      r_chk_y  <= outy;
      r_chk_ok <= 1'b1;
    end
  end

  a_rst_zero : assert property (@(posedge inclk) !inrst_n |-> (outy == '0))
    else $error("simple_and: outy nonzero during reset");
`endif

endmodule

// File: tb/tb_simple_and.sv
// Self-checking bench for simple_and: WIDTH=1 and WIDTH=8 instances driven
// by directed and random stimulus, compared each cycle to a last-capture model.
module tb_simple_and;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       y1;
  logic [7:0] y8;

  int total = 0;
  int bad   = 0;

  // Model: outy is the AND of the most recent enabled sample since reset, else 0.
  logic       m1 = 1'b0;
  logic [7:0] m8 = 8'h00;

  always #5 clk = ~clk;

  simple_and #(.WIDTH(1)) dut1 (
    .inclk(clk), .inrst_n(rst_n), .inen(en), .ina(a1), .inb(b1), .outy(y1)
  );

  simple_and #(.WIDTH(8)) dut8 (
    .inclk(clk), .inrst_n(rst_n), .inen(en), .ina(a8), .inb(b8), .outy(y8)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, compare at next falling edge.
  task automatic step(input logic e, input logic ia, input logic ib,
                      input logic [7:0] xa, input logic [7:0] xb);
    en = e; a1 = ia; b1 = ib; a8 = xa; b8 = xb;
    @(posedge clk);
    if (rst_n === 1'b1 && e === 1'b1) begin
      m1 = ia & ib;
      m8 = xa & xb;
    end
    @(negedge clk);
    check("model_y1", 64'(y1), 64'(m1));
    check("model_y8", 64'(y8), 64'(m8));
  endtask

  // Called at a falling edge: reset pulse entirely between clock edges.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    m1 = 1'b0;
    m8 = 8'h00;
    #1;
    check("async_clr_y1", 64'(y1), 64'd0);
    check("async_clr_y8", 64'(y8), 64'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] tt;
    #1;
    check("reset_y1", 64'(y1), 64'd0);
    check("reset_y8", 64'(y8), 64'd0);
    @(negedge clk);

    // Reset held with enabled all-ones operands, then release
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    check("rst_hold_y1", 64'(y1), 64'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    check("release_y1", 64'(y1), 64'd1);
    check("release_y8", 64'(y8), 64'hFF);

    // Truth table
    for (int i = 0; i < 4; i++) begin
      tt = 2'(i);
      step(1'b1, tt[1], tt[0], 8'h00, 8'h00);
      check("truth_y1", 64'(y1), (i == 3) ? 64'd1 : 64'd0);
    end

    // Enable hold
    step(1'b1, 1'b1, 1'b1, 8'hC3, 8'hFF);
    check("hold_cap_y8", 64'(y8), 64'hC3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("hold_y1", 64'(y1), 64'd1);
      check("hold_y8", 64'(y8), 64'hC3);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("hold_release_y1", 64'(y1), 64'd0);

    // Unknown enable right after reset
    reset_pulse();
    step(1'bx, 1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    check("x_en_next_y1", 64'(y1), 64'd1);

    // Async reset mid-stream
    reset_pulse();
    step(1'b1, 1'b1, 1'b1, 8'h5A, 8'hFF);
    check("post_rst_y1", 64'(y1), 64'd1);
    check("post_rst_y8", 64'(y8), 64'h5A);

    // Width patterns
    step(1'b1, 1'b0, 1'b1, 8'hF0, 8'h3C);
    check("width_f0_3c", 64'(y8), 64'h30);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hA5);
    check("width_ff_a5", 64'(y8), 64'hA5);

    // Random traffic with occasional async resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse();
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule

// File: doc/simple_and.md
Name: simple_and

Overview:
- Registered, enable-gated bitwise AND of two operand vectors.
- Small leaf datapath primitive used as a clocked logic stage and as a bring-up/smoke-test block for the simulation flow.
- Result is captured on the rising clock edge when enabled, and held otherwise.

Parameters:
- WIDTH, 1, bit width of operands ina/inb and result outy; legal range 1..64.

Ports:
- inclk  input  1  system clock; all state updates on the rising edge.
- inrst_n  input  1  asynchronous active-low reset; clears all state.
- inen  input  1  capture enable; result register loads only when high.
- ina  input  WIDTH  operand A.
- inb  input  WIDTH  operand B.
- outy  output  WIDTH  registered result, driven directly from the result register.

Behaviour:
- Interface: one clock, inclk. Reset inrst_n is asynchronous and active-low.
- Reset:
  - inrst_n low forces outy to all zeros immediately, independent of inclk.
  - outy holds zero while inrst_n is low.
  - Reset release is synchronised by the integrator. The first capture occurs on the first rising edge of inclk with inrst_n high.
- Capture:
  - On each rising edge of inclk with inrst_n high and inen high: outy <= ina & inb, per bit.
  - With inen low: outy holds its previous value.
- Latency:
  - 1 cycle. Operands sampled at edge N appear on outy immediately after edge N.
  - No combinational path from ina, inb or inen to outy.
- Width rules:
  - Pure bitwise operation with no carries. Bit k of outy depends only on bit k of ina and inb.
  - No truncation or extension inside the block.
- Unknown inputs:
  - If inen is X/Z at a capture edge, the register is not updated. The RTL treats only inen === 1 as enable, and simulation reports a warning.
  - X on ina/inb propagates per the AND truth table; 0 & X = 0.
- Simultaneous events:
  - inrst_n asserting on the same instant as a rising edge: reset wins and outy = 0.
  - Operand change coincident with an edge: the value present before the edge is sampled, per standard flop semantics.
- Reset mid-operation: outy is cleared immediately. Capture resumes on the first enabled edge after release. No residual state remains.
- Outputs never glitch between edges except on asynchronous reset assertion.
- Include simulation-only assertions:
  - outy stable when inen was low at the previous edge.
  - outy == 0 while inrst_n is low.
  - parameter range check at elaboration.

Test Plan:
- Reset: hold inrst_n low for 2 cycles with ina=1, inb=1, inen=1 -> outy=0 throughout. Release -> outy=1 after the first rising edge.
- Truth table (WIDTH=1, inen=1): apply {ina,inb} = 00, 01, 10, 11 on successive cycles -> outy = 0, 0, 0, 1, each one cycle after the operands.
- Enable hold: capture 11 (outy=1), then drop inen and apply 00 for 3 cycles -> outy stays 1. Raise inen -> outy=0 next edge.
- Enable unknown at start: inen=X for the first edge with ina=inb=1 after reset -> outy remains 0 and a warning is issued. inen=1 on the next edge -> outy=1.
- Async reset mid-stream: outy=1 with inen=1, then pulse inrst_n low between edges -> outy goes to 0 without a clock edge. After release and the next edge with ina=inb=1 -> outy=1.
- Width (WIDTH=8): ina=0xF0, inb=0x3C, inen=1 -> outy=0x30 after one edge. Then ina=0xFF, inb=0xA5 -> outy=0xA5.
